// File: rtl/sdm_pkg.sv
// Shared constants and helpers for the sigma-delta modulator and its CIC decimator.
package sdm_pkg;

  localparam int SDM_K        = 1024;
  localparam int CIC_R        = 64;
  localparam int CIC_N        = 3;
  localparam int CIC_SHIFT    = 8;
  localparam int CIC_OUT_BITS = 12;

  function automatic int clog2_f(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  // Bit growth of an order-n CIC with ratio r, plus sign and one guard bit.
  function automatic int acc_width(input int r, input int n);
    return n * clog2_f(r) + 2;
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section (differential delay 1); the delay only advances on decimated strobes.
module cic_comb_stage #(
  parameter int W = 20
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic signed [W-1:0] x_i,
  output logic signed [W-1:0] y_o
);

  logic signed [W-1:0] dly_q;
  logic signed [W-1:0] dly_d;

  always_comb begin
    if (en_i) begin
      dly_d = x_i;
    end else begin
      dly_d = dly_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dly_q <= '0;
    end else begin
      dly_q <= dly_d;
    end
  end

  assign y_o = x_i - dly_q;

endmodule

// File: rtl/sdm_cic_decimator.sv
// Order-N CIC decimator turning the 1-bit modulator stream into saturated signed PCM words.
module sdm_cic_decimator
  import sdm_pkg::*;
#(
  parameter int R        = CIC_R,
  parameter int N        = CIC_N,
  parameter int SHIFT    = CIC_SHIFT,
  parameter int OUT_BITS = CIC_OUT_BITS
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_en_i,
  input  logic                       in_bit_i,
  output logic signed [OUT_BITS-1:0] out_data_o,
  output logic                       out_valid_o
);

  localparam int ACC_W = acc_width(R, N);
  localparam int CNT_W = clog2_f(R);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);

  logic signed [ACC_W-1:0]    in_s;
  logic                       frame_end_s;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic signed [ACC_W-1:0]    integ_q [N];
  logic signed [ACC_W-1:0]    integ_d [N];
  logic signed [ACC_W-1:0]    cap_q, cap_d;
  logic                       cap_vld_q, cap_vld_d;
  logic signed [ACC_W-1:0]    comb_s [N+1];
  logic signed [63:0]         shifted_s;
  logic signed [OUT_BITS-1:0] out_data_q, out_data_d;
  logic                       out_valid_q, out_valid_d;

  assign in_s        = in_bit_i ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};
  assign frame_end_s = in_en_i && (cnt_q == CNT_LAST);

  // Integrators form a registered cascade: each stage adds its predecessor's old value.
  always_comb begin
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    cap_vld_d = 1'b0;
    for (int i = 0; i < N; i++) begin
      integ_d[i] = integ_q[i];
    end
    if (in_en_i) begin
      cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      integ_d[0] = integ_q[0] + in_s;
      for (int i = 1; i < N; i++) begin
        integ_d[i] = integ_q[i] + integ_q[i-1];
      end
    end else begin
      cnt_d = cnt_q;
    end
    if (frame_end_s) begin
      cap_d     = integ_q[N-1];
      cap_vld_d = 1'b1;
    end else begin
      cap_d     = cap_q;
      cap_vld_d = 1'b0;
    end
  end

  assign comb_s[0] = cap_q;

  for (genvar g = 0; g < N; g++) begin : g_comb
    cic_comb_stage #(
      .W(ACC_W)
    ) u_comb (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .en_i  (cap_vld_q),
      .x_i   (comb_s[g]),
      .y_o   (comb_s[g+1])
    );
  end

  assign shifted_s = 64'(comb_s[N]) >>> SHIFT;

  // The comb/output stage runs off the captured strobe, so it completes regardless of in_en.
  always_comb begin
    out_valid_d = cap_vld_q;
    if (cap_vld_q) begin
      out_data_d = OUT_BITS'(sat_signed(shifted_s, OUT_BITS));
    end else begin
      out_data_d = out_data_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      cap_q       <= '0;
      cap_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        integ_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      cap_vld_q   <= cap_vld_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < N; i++) begin
        integ_q[i] <= integ_d[i];
      end
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_sdm_cic_decimator.sv
// Bench for sdm_cic_decimator: binomial-weight CIC model checked every cycle plus literal pins.
module tb_sdm_cic_decimator;

  localparam int R        = 64;
  localparam int N        = 3;
  localparam int SHIFT    = 8;
  localparam int OUT_BITS = 12;
  localparam int ACC_W    = 20;
  localparam int K        = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst_n  = 1'b0;
  logic                       in_en  = 1'b0;
  logic                       in_bit = 1'b0;
  logic signed [OUT_BITS-1:0] out_data;
  logic                       out_valid;

  sdm_cic_decimator #(
    .R(R), .N(N), .SHIFT(SHIFT), .OUT_BITS(OUT_BITS)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_en_i    (in_en),
    .in_bit_i   (in_bit),
    .out_data_o (out_data),
    .out_valid_o(out_valid)
  );

  int     samples[$];
  longint frames[$];
  bit     pend      = 1'b0;
  longint pend_val  = 0;
  bit     exp_valid = 1'b0;
  longint exp_data  = 0;
  bit     chk_en    = 1'b0;
  int     checks    = 0;
  int     errors    = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint binom(input int a, input int b);
    longint r;
    if (a < b || a < 0) return 0;
    r = 1;
    for (int i = 0; i < b; i++) r = r * (a - i) / (i + 1);
    return r;
  endfunction

  // Last integrator seen after n accepted inputs is sum_j s_j * C(n-1-j, N-1).
  function automatic longint frame_value();
    longint s = 0;
    int n = samples.size();
    for (int j = 0; j < n; j++) s += samples[j] * binom(n - 1 - j, N - 1);
    return s;
  endfunction

  // N-th difference at the decimated rate, wrapped to ACC_W, shifted and saturated.
  function automatic longint cic_out();
    longint s = 0;
    longint w;
    longint q;
    longint hi = (64'sd1 <<< (OUT_BITS - 1)) - 1;
    int f = frames.size() - 1;
    for (int i = 0; i <= N; i++) begin
      if (f - i >= 0) s += ((i % 2 == 1) ? -64'sd1 : 64'sd1) * binom(N, i) * frames[f - i];
    end
    w = s & ((64'sd1 <<< ACC_W) - 1);
    if (w >= (64'sd1 <<< (ACC_W - 1))) w -= (64'sd1 <<< ACC_W);
    q = w >>> SHIFT;
    if (q > hi) q = hi;
    if (q < -hi - 1) q = -hi - 1;
    return q;
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic b);
    if (!r) begin
      samples.delete();
      frames.delete();
      pend      = 1'b0;
      exp_valid = 1'b0;
      exp_data  = 0;
    end else begin
      exp_valid = pend;
      if (pend) exp_data = pend_val;
      pend = 1'b0;
      if (e) begin
        if (samples.size() % R == R - 1) begin
          frames.push_back(frame_value());
          pend_val = cic_out();
          pend     = 1'b1;
        end
        samples.push_back(b ? 1 : -1);
      end
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic b);
    @(negedge clk);
    rst_n  = r;
    in_en  = e;
    in_bit = b;
    @(posedge clk);
    #1;
    model_edge(r, e, b);
  endtask

  // Compare process: DUT outputs against the model on every falling edge.
  initial begin
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("out_valid", out_valid, exp_valid);
        check("out_data", out_data, exp_data);
        if (out_valid) check("no_back_to_back", prev, 0);
        prev = out_valid;
      end
    end
  end

  initial begin
    int  k;
    bit  got_first;
    int  sdm_acc;
    bit  b;
    bit  e;
    int  acc;
    int  since;
    int  nstrobe;
    int  cyc;
    longint diff;
    int  xs [2];
    xs[0] = 512;
    xs[1] = -300;

    // Reset held with in_en=1, then latency to the first strobe.
    cycle(1'b0, 1'b1, 1'b1);
    chk_en = 1'b1;
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    k = 0;
    do begin
      cycle(1'b1, 1'b1, 1'b1);
      k++;
    end while (!out_valid && k < 200);
    check("first_strobe_latency", k, 65);

    // Constant ones: first strobe C(63,3)>>8 = 155, settled +1024.
    cycle(1'b0, 1'b1, 1'b1);
    got_first = 1'b0;
    for (int i = 0; i < 6 * R; i++) begin
      cycle(1'b1, 1'b1, 1'b1);
      if (out_valid && !got_first) begin
        check("dc_first_strobe", out_data, 155);
        got_first = 1'b1;
      end
    end
    check("dc_pos_dut", out_data, 1024);
    check("dc_pos_model", exp_data, 1024);

    // Constant zeros, then alternating bits.
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6 * R; i++) cycle(1'b1, 1'b1, 1'b0);
    check("dc_neg_dut", out_data, -1024);
    check("dc_neg_model", exp_data, -1024);
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6 * R; i++) cycle(1'b1, 1'b1, (i % 2) == 0);
    check("alt_dut", out_data, 0);
    check("alt_model", exp_data, 0);

    // First-order modulator driving the decimator.
    for (int t = 0; t < 2; t++) begin
      cycle(1'b0, 1'b1, 1'b0);
      sdm_acc = 0;
      for (int i = 0; i < 8 * R; i++) begin
        b = (sdm_acc >= 0);
        sdm_acc += xs[t] - (b ? K : -K);
        cycle(1'b1, 1'b1, b);
      end
      diff = longint'(out_data) - xs[t];
      check((t == 0) ? "sdm_pos512_within2" : "sdm_neg300_within2",
            (diff >= -2 && diff <= 2) ? 1 : 0, 1);
    end

    // Random in_en gaps: spacing counted in accepted bits.
    cycle(1'b0, 1'b1, 1'b1);
    acc = 0; since = 0; nstrobe = 0; cyc = 0;
    while (acc < 6 * R && cyc < 4000) begin
      e = 1'($urandom_range(0, 1));
      cycle(1'b1, e, 1'b1);
      cyc++;
      if (out_valid) begin
        if (nstrobe > 0) check("strobe_spacing", since, R);
        nstrobe++;
        since = int'(e);
      end else begin
        since += int'(e);
      end
      acc += int'(e);
    end
    check("rand_accepted", acc, 6 * R);
    check("rand_dc_dut", out_data, 1024);

    // Reset mid-frame at phase 37.
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5 * R + 37; i++) cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check("midreset_valid", out_valid, 0);
    check("midreset_data", out_data, 0);
    k = 0;
    do begin
      cycle(1'b1, 1'b1, 1'b1);
      k++;
    end while (!out_valid && k < 200);
    check("midreset_first_strobe", k, 65);
    for (int i = 0; i < 5 * R; i++) cycle(1'b1, 1'b1, 1'b1);
    check("midreset_dc_dut", out_data, 1024);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
